rcu_rst_seq: RTL and testbench

Parametrised reset sequencer for the reset and clock unit. It stretches an incoming reset and releases `CH_NUM` downstream reset domains one at a time, with a programmable gap before each release. After the sequence completes, it supports a global watchdog re-reset and per-channel software resets. It sits inside `apb4_rcu` between the reset sources (external, watchdog, register-driven software requests) and the per-domain `rst_n` outputs.

---
 rtl/rcu_rst_seq.sv | 169 ++++++++++++++++
 tb/tb_rcu_rst_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rcu_rst_seq.sv
// Reset sequencer: stretches the incoming reset, then releases CH_NUM domains in order.
// Optional RCU_RST_SEQ_CAUSE_EN adds cause_o reporting the most recent reset cause.
module rcu_rst_seq #(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned STRETCH   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        wdt_rst_n_i,
    input  logic [CH_NUM-1:0]           sw_rst_req_i,
    input  logic [CH_NUM*CNT_WIDTH-1:0] dly_i,
    output logic [CH_NUM-1:0]           rst_n_o,
    output logic                        busy_o,
`ifdef RCU_RST_SEQ_CAUSE_EN
    output logic [1:0]                  cause_o,
`endif
    output logic                        done_o
);

    localparam int unsigned SCNT_W = $clog2(STRETCH + 1);
    localparam int unsigned IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [SCNT_W-1:0]     r_scnt, w_scnt_nxt;
    logic [CNT_WIDTH-1:0]  r_rcnt, w_rcnt_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [CH_NUM-1:0]     r_rst_n, w_rst_n_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic [SCNT_W-1:0]     r_sw_cnt [CH_NUM];
    logic [SCNT_W-1:0]     w_sw_cnt_nxt [CH_NUM];
    logic [CNT_WIDTH-1:0]  w_dly [CH_NUM];
`ifdef RCU_RST_SEQ_CAUSE_EN
    logic [1:0]            r_cause, w_cause_nxt;
`endif

    for (genvar g = 0; g < CH_NUM; g++) begin : g_dly
        assign w_dly[g] = dly_i[g*CNT_WIDTH +: CNT_WIDTH];
    end

    // Next-state and next-output logic; watchdog overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_rcnt_nxt  = r_rcnt;
        w_idx_nxt   = r_idx;
        w_rst_n_nxt = r_rst_n;
        w_done_nxt  = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            w_sw_cnt_nxt[k] = r_sw_cnt[k];
        end
`ifdef RCU_RST_SEQ_CAUSE_EN
        w_cause_nxt = r_cause;
`endif

        if (!wdt_rst_n_i) begin
            w_state_nxt = ST_ASSERT;
            w_scnt_nxt  = '0;
            w_rcnt_nxt  = '0;
            w_idx_nxt   = '0;
            w_rst_n_nxt = '0;
            for (int k = 0; k < CH_NUM; k++) begin
                w_sw_cnt_nxt[k] = '0;
            end
`ifdef RCU_RST_SEQ_CAUSE_EN
            w_cause_nxt = 2'b01;
`endif
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_scnt == SCNT_W'(STRETCH - 1)) begin
                        w_state_nxt = ST_RELEASE;
                        w_scnt_nxt  = '0;
                        w_rcnt_nxt  = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_rcnt == w_dly[r_idx]) begin
                        w_rst_n_nxt[r_idx] = 1'b1;
                        w_rcnt_nxt         = '0;
                        w_idx_nxt          = r_idx + 1'b1;
                        if (r_idx == IDX_W'(CH_NUM - 1)) begin
                            w_state_nxt = ST_RUN;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Per-channel software resets; a new request retriggers the stretch.
                    for (int k = 0; k < CH_NUM; k++) begin
                        if (sw_rst_req_i[k]) begin
                            w_sw_cnt_nxt[k] = SCNT_W'(STRETCH);
                            w_rst_n_nxt[k]  = 1'b0;
                        end else if (r_sw_cnt[k] != '0) begin
                            w_sw_cnt_nxt[k] = r_sw_cnt[k] - 1'b1;
                            if (r_sw_cnt[k] == SCNT_W'(1)) begin
                                w_rst_n_nxt[k] = 1'b1;
                            end
                        end
                    end
`ifdef RCU_RST_SEQ_CAUSE_EN
                    if (|sw_rst_req_i) begin
                        w_cause_nxt = 2'b10;
                    end
`endif
                end
                default: begin
                    w_state_nxt = ST_ASSERT;
                    w_scnt_nxt  = '0;
                    w_rst_n_nxt = '0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != ST_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= ST_ASSERT;
            r_scnt  <= '0;
            r_rcnt  <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) begin
                r_sw_cnt[k] <= '0;
            end
`ifdef RCU_RST_SEQ_CAUSE_EN
            r_cause <= 2'b00;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_idx   <= w_idx_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            for (int k = 0; k < CH_NUM; k++) begin
                r_sw_cnt[k] <= w_sw_cnt_nxt[k];
            end
`ifdef RCU_RST_SEQ_CAUSE_EN
            r_cause <= w_cause_nxt;
`endif
        end
    end

    assign rst_n_o = r_rst_n;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
`ifdef RCU_RST_SEQ_CAUSE_EN
    assign cause_o = r_cause;
`endif

endmodule

// File: tb/tb_rcu_rst_seq.sv
// Bench for rcu_rst_seq: directed scenarios plus random traffic against an edge-numbered model.
module tb_rcu_rst_seq;

    localparam int unsigned CH_NUM    = 4;
    localparam int unsigned CNT_WIDTH = 8;
    localparam int unsigned STRETCH   = 16;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        wdt_rst_n = 1'b1;
    logic [CH_NUM-1:0]           sw_req = '0;
    logic [CH_NUM*CNT_WIDTH-1:0] dly = '0;
    logic [CH_NUM-1:0]           rst_n_o;
    logic                        busy_o;
    logic                        done_o;
`ifdef RCU_RST_SEQ_CAUSE_EN
    logic [1:0]                  cause_o;
`endif

    int checks = 0;
    int errors = 0;

    // Model: seq is the number of the last edge in the current sequence (-1 = held in reset).
    int seq = -1;
    int rel [CH_NUM];
    int sw_until [CH_NUM];
    int cause_m = 0;

    rcu_rst_seq #(.CH_NUM(CH_NUM), .CNT_WIDTH(CNT_WIDTH), .STRETCH(STRETCH)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .wdt_rst_n_i (wdt_rst_n),
        .sw_rst_req_i(sw_req),
        .dly_i       (dly),
        .rst_n_o     (rst_n_o),
        .busy_o      (busy_o),
`ifdef RCU_RST_SEQ_CAUSE_EN
        .cause_o     (cause_o),
`endif
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [CH_NUM*CNT_WIDTH-1:0] pack(input int d0, input int d1,
                                                         input int d2, input int d3);
        logic [CH_NUM*CNT_WIDTH-1:0] v;
        v = {CNT_WIDTH'(d3), CNT_WIDTH'(d2), CNT_WIDTH'(d1), CNT_WIDTH'(d0)};
        return v;
    endfunction

    // Channel k rises at STRETCH + sum(dly[0..k]) + k.
    task automatic compute_rel();
        int acc;
        acc = STRETCH;
        for (int k = 0; k < CH_NUM; k++) begin
            acc += int'(dly[k*CNT_WIDTH +: CNT_WIDTH]);
            rel[k] = acc + k;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t seq=%0d: observed %h expected %h", tag, $time, seq, obs, exp);
        end
    endtask

    task automatic model_edge();
        int prev;
        prev = seq;
        if (!rst_n) begin
            seq = -1;
            cause_m = 0;
            for (int k = 0; k < CH_NUM; k++) sw_until[k] = 0;
        end else if (!wdt_rst_n) begin
            seq = -1;
            cause_m = 1;
            for (int k = 0; k < CH_NUM; k++) sw_until[k] = 0;
        end else begin
            seq++;
            if (seq == 0) compute_rel();
            if (prev >= rel[CH_NUM-1] && sw_req != '0) begin
                cause_m = 2;
                for (int k = 0; k < CH_NUM; k++)
                    if (sw_req[k]) sw_until[k] = seq + int'(STRETCH);
            end
        end
    endtask

    task automatic tick();
        logic [CH_NUM-1:0] exp_rst;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int k = 0; k < CH_NUM; k++)
            exp_rst[k] = (seq >= 0) && (seq >= rel[k]) && (seq >= sw_until[k]);
        chk("rst_n_o", 32'(rst_n_o), 32'(exp_rst));
        chk("busy_o", 32'(busy_o), 32'(seq < rel[CH_NUM-1]));
        chk("done_o", 32'(done_o), 32'(seq == rel[CH_NUM-1]));
`ifdef RCU_RST_SEQ_CAUSE_EN
        chk("cause_o", 32'(cause_o), 32'(cause_m));
`endif
    endtask

    task automatic run_to(input int e);
        for (int i = 0; i < 2000 && seq != e; i++) tick();
        if (seq != e) begin
            errors++;
            $error("FAIL run_to: observed seq %0d expected %0d", seq, e);
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < CH_NUM; k++) sw_until[k] = 0;
        dly = pack(2, 0, 5, 1);
        compute_rel();

        // Power-on sequence, with requests during ASSERT that must be ignored
        repeat (3) tick();
        chk("reset_rst_n", 32'(rst_n_o), 32'h0);
        chk("reset_busy", 32'(busy_o), 32'h1);
        chk("reset_done", 32'(done_o), 32'h0);
        rst_n = 1'b1;
        run_to(1);
        sw_req = 4'hF;
        run_to(5);
        sw_req = '0;
        run_to(17);
        chk("po_e17", 32'(rst_n_o), 32'h0);
        tick();
        chk("po_e18", 32'(rst_n_o), 32'h1);
        tick();
        chk("po_e19", 32'(rst_n_o), 32'h3);
        run_to(24);
        chk("po_e24", 32'(rst_n_o), 32'h3);
        tick();
        chk("po_e25", 32'(rst_n_o), 32'h7);
        run_to(26);
        chk("po_e26_done", 32'(done_o), 32'h0);
        tick();
        chk("po_e27_rst", 32'(rst_n_o), 32'hF);
        chk("po_e27_done", 32'(done_o), 32'h1);
        chk("po_e27_busy", 32'(busy_o), 32'h0);
        tick();
        chk("po_e28_done", 32'(done_o), 32'h0);

        // All-zero delays
        rst_n = 1'b0;
        dly = '0;
        tick();
        rst_n = 1'b1;
        run_to(15);
        chk("zero_e15", 32'(rst_n_o), 32'h0);
        tick(); chk("zero_e16", 32'(rst_n_o), 32'h1);
        tick(); chk("zero_e17", 32'(rst_n_o), 32'h3);
        tick(); chk("zero_e18", 32'(rst_n_o), 32'h7);
        tick(); chk("zero_e19", 32'(rst_n_o), 32'hF);
        chk("zero_e19_done", 32'(done_o), 32'h1);

        // Maximum delay on ch0 must not wrap
        rst_n = 1'b0;
        dly = pack(255, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        run_to(270);
        chk("max_e270", 32'(rst_n_o), 32'h0);
        tick();
        chk("max_e271", 32'(rst_n_o), 32'h1);
        run_to(274);
        chk("max_e274_done", 32'(done_o), 32'h1);

        // Software reset on ch2 with retrigger
        run_to(280);
        sw_req = 4'b0100;
        tick();
        n = seq;
        sw_req = '0;
        run_to(n + 5);
        chk("sw_n5", 32'(rst_n_o), 32'hB);
        run_to(n + 9);
        sw_req = 4'b0100;
        tick();
        sw_req = '0;
        run_to(n + 25);
        chk("sw_n25", 32'(rst_n_o), 32'hB);
        tick();
        chk("sw_n26", 32'(rst_n_o), 32'hF);

        // Watchdog during RELEASE after ch0/ch1 are out
        rst_n = 1'b0;
        dly = pack(0, 0, 3, 2);
        tick();
        rst_n = 1'b1;
        run_to(17);
        chk("wdt_pre", 32'(rst_n_o), 32'h3);
        wdt_rst_n = 1'b0;
        repeat (5) tick();
        chk("wdt_rst", 32'(rst_n_o), 32'h0);
        chk("wdt_busy", 32'(busy_o), 32'h1);
        wdt_rst_n = 1'b1;
        run_to(15);
        chk("wdt_e15", 32'(rst_n_o), 32'h0);
        tick();
        chk("wdt_e16", 32'(rst_n_o), 32'h1);
        run_to(28);

        // Watchdog and software request on the same edge
        wdt_rst_n = 1'b0;
        sw_req = 4'hF;
        tick();
        chk("wdtsw_rst", 32'(rst_n_o), 32'h0);
        chk("wdtsw_busy", 32'(busy_o), 32'h1);
`ifdef RCU_RST_SEQ_CAUSE_EN
        chk("wdtsw_cause", 32'(cause_o), 32'h1);
`endif
        wdt_rst_n = 1'b1;
        sw_req = '0;
        run_to(30);
        chk("wdtsw_rerun", 32'(rst_n_o), 32'hF);

        // rst_n_i during an active software reset
        sw_req = 4'b0010;
        tick();
        sw_req = '0;
        repeat (3) tick();
        chk("mid_sw", 32'(rst_n_o), 32'hD);
        rst_n = 1'b0;
        tick();
        chk("mid_rst", 32'(rst_n_o), 32'h0);
        chk("mid_busy", 32'(busy_o), 32'h1);
        chk("mid_done", 32'(done_o), 32'h0);
        rst_n = 1'b1;
        run_to(30);
        chk("mid_rerun", 32'(rst_n_o), 32'hF);

        // Random traffic; dly only changes outside ASSERT/RELEASE
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            wdt_rst_n = ($urandom_range(0, 149) != 0);
            sw_req    = ($urandom_range(0, 9) == 0) ? CH_NUM'($urandom) : '0;
            if ((seq < 0 || seq >= rel[CH_NUM-1]) && $urandom_range(0, 19) == 0)
                dly = pack($urandom_range(0, 7), $urandom_range(0, 7),
                           $urandom_range(0, 7), $urandom_range(0, 7));
            tick();
        end
        rst_n = 1'b1;
        wdt_rst_n = 1'b1;
        sw_req = '0;
        repeat (80) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
